// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, data-memory wait, branch redirect.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 15
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWrite,
    input  logic             ex_MemtoReg,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             Branch_ALU,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_bubble,
    output logic [1:0]       state,
    output logic             timeout_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] load_use_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_REDIRECT = 2'b10
    } state_e;

    localparam logic [7:0] WAIT_MAX_W = 8'(MEM_WAIT_MAX);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       mem_stall;
    logic       load_use;

    assign mem_stall = mem_req & ~mem_ready;

    // A just-flushed ID slot holds no real instruction, so REDIRECT masks the hazard.
    assign load_use = ex_MemtoReg & ex_RegWrite & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd))) &
                      (state_q != ST_REDIRECT);

    always_comb begin
        pc_we         = 1'b0;
        pc_redirect   = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                mem_wb_bubble = 1'b1;
            end else if (Branch_ALU) begin
                pc_we        = 1'b1;
                pc_redirect  = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_en     = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_en    = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en     = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_en    = 1'b1;
            end else begin
                pc_we        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        err_d      = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall)       state_d = ST_MEM_WAIT;
                else if (Branch_ALU) state_d = ST_REDIRECT;
                else                 state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = (wait_cnt_q >= WAIT_MAX_W) ? WAIT_MAX_W : wait_cnt_q + 8'd1;
                    if (wait_cnt_d == WAIT_MAX_W) err_d = 1'b1;
                end else if (Branch_ALU) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                state_d = mem_stall ? ST_MEM_WAIT : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign state       = state_q;
    assign timeout_err = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, lu_q;
    logic             lu_bubble;

    // The load-use bubble is the only action that flushes ID_EX without redirecting.
    assign lu_bubble = id_ex_flush & ~pc_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            if (!pc_we)      stall_q <= stall_q + 1'b1;
            if (pc_redirect) flush_q <= flush_q + 1'b1;
            if (lu_bubble)   lu_q    <= lu_q + 1'b1;
        end
    end

    assign stall_cycles    = stall_q;
    assign flush_events    = flush_q;
    assign load_use_events = lu_q;
`endif

endmodule
